data_mem_responder: RTL

//  Memory-side responder for the multi-cycle CPU's load/store path.

---
 rtl/data_mem_responder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Memory-side load/store responder: one request at a time, fixed wait states,
// byte-lane merged stores, full-word reads, fault on misaligned/out-of-range.
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        addr_err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, stateNext;
  logic [3:0]  waitCnt;
  logic        wrQ, errQ;
  logic [AW+1:0] addrQ;
  logic [1:0]  sizeQ;
  logic [31:0] wdataQ;
  logic [31:0] mem [DEPTH];

  logic        faultIn, misalign, outRange;
  logic        opWr, opErr, doCommit;
  logic [AW+1:0] opAddr;
  logic [1:0]  opSize;
  logic [31:0] opData, laneData;
  logic [3:0]  byteEn;

  always_comb begin
    misalign = 1'b0;
    case (size)
      2'b01:   misalign = addr[0];
      2'b10:   misalign = 1'b0;
      default: misalign = (addr[1:0] != 2'b00);
    endcase
    outRange = ({1'b0, addr} >= (33'(DEPTH) * 33'd4));
    faultIn  = misalign | outRange;
  end

  // With zero wait states the access happens on the accept edge itself, so in
  // IDLE the operation is taken straight from the inputs instead of the latches.
  always_comb begin
    opWr   = (state == IDLE) ? wr               : wrQ;
    opErr  = (state == IDLE) ? faultIn          : errQ;
    opAddr = (state == IDLE) ? addr[AW+1:0]     : addrQ;
    opSize = (state == IDLE) ? size             : sizeQ;
    opData = (state == IDLE) ? wdata            : wdataQ;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (req) stateNext = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (waitCnt == 4'(WAIT_CYCLES - 1)) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge clock) begin
    if (reset)                                     waitCnt <= '0;
    else if (state == WAIT && stateNext == WAIT)   waitCnt <= waitCnt + 4'd1;
    else                                           waitCnt <= '0;
  end

  always_ff @(posedge clock) begin
    if (state == IDLE && req) begin
      wrQ    <= wr;
      errQ   <= faultIn;
      addrQ  <= addr[AW+1:0];
      sizeQ  <= size;
      wdataQ <= wdata;
    end
  end

  always_comb begin
    byteEn   = 4'b0000;
    laneData = opData;
    case (opSize)
      2'b10: begin
        byteEn   = 4'b0001 << opAddr[1:0];
        laneData = {4{opData[7:0]}};
      end
      2'b01: begin
        byteEn   = opAddr[1] ? 4'b1100 : 4'b0011;
        laneData = {2{opData[15:0]}};
      end
      default: byteEn = 4'b1111;
    endcase
  end

  // Both stores and loads land on the edge entering RESP; reset on that edge cancels them.
  assign doCommit = !reset && (stateNext == RESP) && (state != RESP) && !opErr;

  always_ff @(posedge clock) begin
    if (doCommit && opWr)
      for (int b = 0; b < 4; b++)
        if (byteEn[b]) mem[opAddr[AW+1:2]][8*b +: 8] <= laneData[8*b +: 8];
  end

  always_ff @(posedge clock) begin
    if (reset)                 rdata <= '0;
    else if (doCommit && !opWr) rdata <= mem[opAddr[AW+1:2]];
  end

  assign ready    = (state == RESP);
  assign addr_err = (state == RESP) && errQ;
  assign busy     = (state != IDLE);

endmodule
